lowpass_v2: RTL and testbench
=============================

# lowpass_v2

First-order IIR low-pass filter (exponential moving average) for signed sample streams. It runs at the sample clock and accepts one new sample every cycle. A runtime-programmable fractional coefficient `alpha_i` sets the corner frequency. It sits in the signal-conditioning path ahead of downstream processing, and several instances with different coefficients may share one input.

## Interface
- `WIDTH`, default 16: width of the signed input and output samples.
- `alpha_WIDTH`, default 32: width of the unsigned coefficient. This is also the number of fractional bits carried in the filter state.

Ports:
- `clk`, input, 1 bit: clock. All state updates on the rising edge.
- `reset`, input, 1 bit: synchronous, active-low. Sampled on the rising edge of `clk`.
- `data_i`, input, signed `WIDTH` bits: input sample, taken on every rising edge.
- `alpha_i`, input, unsigned `alpha_WIDTH` bits: filter coefficient, equal to `alpha_i / 2^alpha_WIDTH`. It may change on any cycle and takes effect on the next edge.
- `data_o`, output, signed `WIDTH` bits: filtered sample.

## Operation
- **State:** register `A`, signed, `WIDTH + alpha_WIDTH` bits, with `alpha_WIDTH` fractional bits (`AW` below).
- **Update on each rising edge, when `reset` = 1:**
  - `diff = (data_i << AW) - A`, computed at `WIDTH + AW + 1` bits with no overflow.
  - `prod = diff * {0, alpha_i}`, computed at full precision with `alpha_i` treated as unsigned.
  - `A <= A + (prod >>> AW)`, an arithmetic shift, so the result is floored.
- **Range:** because `alpha_i` < 2^AW, `A` is always a convex combination of the old state and the input. It therefore never leaves the range of a `WIDTH`-bit signed integer, and no saturation is needed on `A`.
- **Output:** `data_o` is `A` rounded to the nearest integer.
  - Add 2^(AW-1) and take bits `[AW+WIDTH-1 : AW]`. Exact halves round toward +infinity.
  - If rounding would exceed the maximum positive value 2^(WIDTH-1)-1, clamp `data_o` to that maximum.
- **Coefficient range:**
  - `alpha_i` = 0: state is frozen.
  - `alpha_i` = 2^AW-1: output tracks the input.
  - `alpha_i` = 2^(AW-1): equivalent to a gain of 0.5 per step.
- **Reset:** when `reset` = 0 at an edge, `A` <= 0, so `data_o` = 0. This applies at any time, including mid-operation. Filtering restarts from zero on the first edge with `reset` = 1.
- **Coefficient changes:** a change of `alpha_i` alters only the following update. There are no transients beyond the new recursion.

## Timing
- **Output path:** `data_o` is a function of register `A` only, through the round and clamp logic. It is glitch-free relative to `clk`, with no combinational path from `data_i` or `alpha_i` to `data_o`.
- **Latency:** one cycle. A sample present at edge n is reflected in `data_o` immediately after edge n.
- **Throughput:** one sample per clock. There is no handshake and no valid signal.
- **After reset:** `data_o` = 0 from the first edge at which `reset` is low, until the first edge with `reset` high.
- **Clock rate:** the single-cycle multiply-accumulate must close timing at the target sample clock. The multiplier may use DSP cascades but must not add latency.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with `data_i` = 12345 and `alpha_i` = 2^31.
  - `data_o` = 0 throughout.
  - After release, `data_o` = 6173 at the first edge (6172.5 rounds up).
- **Positive step, half gain:** `alpha_i` = 2^31, `data_i` = 1000 from a reset state.
  - `data_o` = 500, 750, 875, 938 (937.5 rounds up), then converges to 1000.
- **Negative step:** `alpha_i` = 2^31, `data_i` = -1000 from reset.
  - `data_o` = -500, -750, -875, -937, then converges to -1000.
- **Pass-through:** `alpha_i` = 4294967295 with a ramp input.
  - `data_o` equals `data_i` of the same edge every cycle.
  - With `data_i` = 32767 held, `data_o` = 32767 (no wrap).
- **Hold and slow filters:**
  - `alpha_i` = 0 after settling at 1000: `data_o` stays 1000 for any input.
  - `alpha_i` = 42950 with a step to 10000: `data_o` rises by roughly 0.1 per cycle, reaching about 6321 after 100000 cycles (±2).
- **Reset mid-stream and coefficient switch:**
  - Pulse `reset` = 0 for one cycle while settled at -20000: `data_o` = 0 on that edge, then resumes filtering from 0.
  - Change `alpha_i` from 2^31 to 2^30 mid-step: the next update uses a gain of 0.25.

Source files
------------

// File: rtl/lowpass_v2_if.sv
// Sample-stream bundle for lowpass_v2: input sample, coefficient and filtered output.
interface lowpass_v2_if #(
    parameter int WIDTH       = 16,
    parameter int alpha_WIDTH = 32
);
    logic signed [WIDTH-1:0]       data_i;
    logic        [alpha_WIDTH-1:0] alpha_i;
    logic signed [WIDTH-1:0]       data_o;

    // Source side: drives samples and coefficient, observes the filtered output.
    modport master (
        output data_i,
        output alpha_i,
        input  data_o
    );

    // Filter side.
    modport slave (
        input  data_i,
        input  alpha_i,
        output data_o
    );
endinterface

// File: rtl/lowpass_v2.sv
// First-order IIR low-pass (exponential moving average) with a runtime
// fractional coefficient alpha_i / 2^alpha_WIDTH. One sample per clock,
// one cycle of latency, output rounded to nearest and clamped at +max.
module lowpass_v2 #(
    parameter int WIDTH       = 16,
    parameter int alpha_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    lowpass_v2_if.slave  bus
);
    localparam int AW = alpha_WIDTH;
    localparam int SW = WIDTH + AW;       // state width, AW fractional bits
    localparam int RW = SW + 1;           // room for the rounding carry
    localparam int PW = SW + AW + 2;      // full-precision product width

    localparam logic [RW-1:0]   ROUND_HALF = RW'(1) << (AW - 1);
    localparam logic [WIDTH-1:0] OUT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};

    logic signed [SW-1:0]    r_acc;
    logic signed [SW-1:0]    w_data_fx;
    logic signed [PW-1:0]    w_diff;
    logic signed [PW-1:0]    w_alpha;
    logic signed [PW-1:0]    w_prod;
    logic signed [SW-1:0]    w_step;
    logic        [RW-1:0]    w_round_sum;
    logic                    w_round_ovf;

    // Update term: alpha * (x - A), floored back to the state's fixed-point grid.
    always_comb begin
        w_data_fx = {bus.data_i, {AW{1'b0}}};
        // Both operands are extended to the full product width so the
        // multiply is exact; alpha is zero-extended because it is unsigned.
        w_diff    = PW'(w_data_fx) - PW'(r_acc);
        w_alpha   = PW'({1'b0, bus.alpha_i});
        w_prod    = w_diff * w_alpha;
        // The arithmetic shift floors; the result always fits the state
        // because the new state is a convex mix of old state and input.
        w_step    = SW'(w_prod >>> AW);
    end

    // State register: A moves a fraction alpha of the way toward the input.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it sits inside the clocked
        // branch and is absent from the sensitivity list.
        if (!reset) begin
            r_acc <= '0;
        end else begin
            r_acc <= r_acc + w_step;
        end
    end

    // Output: round A to nearest (halves toward +inf), clamp at the positive limit.
    always_comb begin
        w_round_sum = RW'(r_acc) + ROUND_HALF;
        // A carry into the sign bit means the rounded value passed +max.
        w_round_ovf = ~w_round_sum[RW-1] & w_round_sum[RW-2];
        if (w_round_ovf) begin
            bus.data_o = OUT_MAX;
        end else begin
            bus.data_o = WIDTH'(w_round_sum >>> AW);
        end
    end
endmodule

// File: tb/tb_lowpass_v2.sv
// Self-checking bench for lowpass_v2: table of per-cycle vectors plus
// hand-written sequences for reset pulses, coefficient switch and slow filter.
module tb_lowpass_v2;
    localparam int WIDTH = 16;
    localparam int AWID  = 32;

    localparam logic [31:0] A_HALF = 32'h8000_0000;
    localparam logic [31:0] A_QTR  = 32'h4000_0000;
    localparam logic [31:0] A_ONE  = 32'hFFFF_FFFF;
    localparam logic [31:0] A_ZERO = 32'h0000_0000;
    localparam logic [31:0] A_SLOW = 32'd42950;

    typedef struct {
        logic                    rst_n;
        logic signed [WIDTH-1:0] data;
        logic [AWID-1:0]         alpha;
        int                      expected;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    lowpass_v2_if #(.WIDTH(WIDTH), .alpha_WIDTH(AWID)) bus ();

    lowpass_v2 #(.WIDTH(WIDTH), .alpha_WIDTH(AWID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: data_o=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_near(input string name, input int actual, input int expected, input int tol);
        n_checks++;
        if (actual < expected - tol || actual > expected + tol) begin
            n_fail++;
            $display("FAIL %s: data_o=%0d expected=%0d +/-%0d", name, actual, expected, tol);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic cycle(input logic r, input logic signed [WIDTH-1:0] d, input logic [AWID-1:0] a);
        reset       = r;
        bus.data_i  = d;
        bus.alpha_i = a;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input int d, input logic [AWID-1:0] a, input int e);
        vec_t v;
        v.rst_n    = r;
        v.data     = d[WIDTH-1:0];
        v.alpha    = a;
        v.expected = e;
        vecs.push_back(v);
    endtask

    initial begin
        clk         = 1'b0;
        reset       = 1'b0;
        bus.data_i  = '0;
        bus.alpha_i = '0;
        n_checks    = 0;
        n_fail      = 0;

        // Reset held for 3 cycles, then first update rounds 6172.5 up.
        add(0, 12345, A_HALF, 0);
        add(0, 12345, A_HALF, 0);
        add(0, 12345, A_HALF, 0);
        add(1, 12345, A_HALF, 6173);
        // Positive step, half gain.
        add(0, 1000, A_HALF, 0);
        add(1, 1000, A_HALF, 500);
        add(1, 1000, A_HALF, 750);
        add(1, 1000, A_HALF, 875);
        add(1, 1000, A_HALF, 938);
        add(1, 1000, A_HALF, 969);
        add(1, 1000, A_HALF, 984);
        add(1, 1000, A_HALF, 992);
        add(1, 1000, A_HALF, 996);
        add(1, 1000, A_HALF, 998);
        add(1, 1000, A_HALF, 999);
        add(1, 1000, A_HALF, 1000);
        add(1, 1000, A_HALF, 1000);
        // Frozen state with alpha = 0.
        add(1, -5000, A_ZERO, 1000);
        add(1, 32767, A_ZERO, 1000);
        add(1, -32768, A_ZERO, 1000);
        // Negative step, half gain: halves round toward +inf.
        add(0, -1000, A_HALF, 0);
        add(1, -1000, A_HALF, -500);
        add(1, -1000, A_HALF, -750);
        add(1, -1000, A_HALF, -875);
        add(1, -1000, A_HALF, -937);
        add(1, -1000, A_HALF, -969);
        add(1, -1000, A_HALF, -984);
        add(1, -1000, A_HALF, -992);
        add(1, -1000, A_HALF, -996);
        add(1, -1000, A_HALF, -998);
        add(1, -1000, A_HALF, -999);
        add(1, -1000, A_HALF, -1000);
        // Pass-through with maximal alpha, including both rails.
        add(1, -32768, A_ONE, -32768);
        add(1, -20000, A_ONE, -20000);
        add(1, -1, A_ONE, -1);
        add(1, 0, A_ONE, 0);
        add(1, 1, A_ONE, 1);
        add(1, 7, A_ONE, 7);
        add(1, 5000, A_ONE, 5000);
        add(1, 32767, A_ONE, 32767);
        add(1, 32767, A_ONE, 32767);
        add(1, -32768, A_ONE, -32768);
        add(1, 32767, A_ONE, 32767);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].data, vecs[i].alpha);
            check($sformatf("vec%0d", i), int'(bus.data_o), vecs[i].expected);
        end

        // Settle at -20000, then a one-cycle reset pulse restarts from zero.
        cycle(0, -20000, A_HALF);
        for (int k = 0; k < 40; k++) cycle(1, -20000, A_HALF);
        check("settled_m20000", int'(bus.data_o), -20000);
        cycle(0, -20000, A_HALF);
        check("midreset_zero", int'(bus.data_o), 0);
        cycle(1, -20000, A_HALF);
        check("midreset_resume1", int'(bus.data_o), -10000);
        cycle(1, -20000, A_HALF);
        check("midreset_resume2", int'(bus.data_o), -15000);

        // Coefficient switch from 0.5 to 0.25 mid-step.
        cycle(0, 1000, A_HALF);
        cycle(1, 1000, A_HALF);
        check("switch_half", int'(bus.data_o), 500);
        cycle(1, 1000, A_QTR);
        check("switch_qtr1", int'(bus.data_o), 625);
        cycle(1, 1000, A_QTR);
        check("switch_qtr2", int'(bus.data_o), 719);
        cycle(1, 1000, A_QTR);
        check("switch_qtr3", int'(bus.data_o), 789);

        // Slow filter: 10000 * (1 - (1 - 42950/2^32)^5000) ~= 487.7.
        cycle(0, 10000, A_SLOW);
        cycle(1, 10000, A_SLOW);
        check("slow_first", int'(bus.data_o), 0);
        for (int k = 1; k < 5000; k++) cycle(1, 10000, A_SLOW);
        check_near("slow_5000", int'(bus.data_o), 488, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
